serial_word_rx: RTL and testbench

Downstream receiver for the 32-bit serial word link. It samples a serial data line framed by an enable strobe, reassembles each frame into a parallel word, and checks the frame length. Good words are pushed into a small FIFO that is drained by the order-processing logic through a valid/pop handshake. Runs on the same `clk` as the transmitter that drives the link.

---
 rtl/serial_word_rx.sv | 134 +++++++++++++
 tb/tb_serial_word_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// Serial word receiver: reassembles strobe-framed MSB-first bits into words and queues them in a FWFT FIFO.
// Optional SERIAL_RX_SYNC_EN adds a 2-flop synchronizer on com_en and data_in.
module serial_word_rx #(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned LEAD_CYC   = 1,
   parameter int unsigned TRAIL_CYC  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              com_en,
   input  logic              data_in,
   input  logic              rd_en,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              frame_err,
   output logic              overflow,
   output logic              busy
);
   localparam int unsigned FRAME   = LEAD_CYC + WORD_W + TRAIL_CYC;
   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned DATA_LO = LEAD_CYC;
   localparam int unsigned DATA_HI = LEAD_CYC + WORD_W;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic com_s, din_s;

`ifdef SERIAL_RX_SYNC_EN
   logic [1:0] com_sync, din_sync;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         com_sync <= '0;
         din_sync <= '0;
      end else begin
         com_sync <= {com_sync[0], com_en};
         din_sync <= {din_sync[0], data_in};
      end
   end
   assign com_s = com_sync[1];
   assign din_s = din_sync[1];
`else
   assign com_s = com_en;
   assign din_s = data_in;
`endif

   typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;
   state_t            state, state_n;
   logic [7:0]        cnt, cnt_n, k;
   logic [WORD_W-1:0] shreg, shreg_n;
   logic              good, bad;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      good    = 1'b0;
      bad     = 1'b0;
      // The IDLE->RECV edge is sample 0; later samples are numbered by the counter.
      k       = (state == IDLE) ? 8'd0 : cnt;
      if (state != SYNC && com_s && 32'(k) >= DATA_LO && 32'(k) < DATA_HI)
         shreg_n = {shreg[WORD_W-2:0], din_s};
      case (state)
         SYNC: if (!com_s) state_n = IDLE;
         IDLE: begin
            if (com_s) begin
               state_n = RECV;
               cnt_n   = 8'd1;
            end
         end
         RECV: begin
            if (com_s) begin
               if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
            end else begin
               state_n = IDLE;
               if (cnt != 8'hFF && 32'(cnt) == FRAME) good = 1'b1;
               else                                   bad  = 1'b1;
            end
         end
         default: state_n = SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SYNC;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         shreg <= shreg_n;
      end
   end

   logic [WORD_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wptr, rptr, wptr_n, rptr_n;
   logic              full, pop, push, ovf;
   logic [WORD_W-1:0] head_n;

   always_comb begin
      full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      pop    = rd_en && rd_valid;
      push   = good && (!full || pop);
      ovf    = good && full && !pop;
      wptr_n = push ? wptr + PTR_ONE : wptr;
      rptr_n = pop  ? rptr + PTR_ONE : rptr;
      // A word pushed into a FIFO that is empty after this cycle's pop becomes the head directly.
      head_n = (push && wptr == rptr_n) ? shreg : mem[rptr_n[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr      <= '0;
         rptr      <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         wptr      <= wptr_n;
         rptr      <= rptr_n;
         rd_valid  <= (wptr_n != rptr_n);
         if (wptr_n != rptr_n) rd_data <= head_n;
         frame_err <= bad;
         overflow  <= ovf;
         busy      <= (state_n == RECV);
      end
   end
endmodule

// File: tb/tb_serial_word_rx.sv
// Randomized bench for serial_word_rx against a frame/queue-level reference model.
// Honours SERIAL_RX_SYNC_EN by delaying the modelled link inputs by two cycles.
module tb_serial_word_rx;
   localparam int W     = 32;
   localparam int LEAD  = 1;
   localparam int TRAIL = 1;
   localparam int DEPTH = 4;
   localparam int FRAME = LEAD + W + TRAIL;
`ifdef SERIAL_RX_SYNC_EN
   localparam int SYNC_STAGES = 2;
`else
   localparam int SYNC_STAGES = 0;
`endif

   logic         clk = 1'b0;
   logic         reset, com_en, data_in, rd_en;
   logic [W-1:0] rd_data;
   logic         rd_valid, frame_err, overflow, busy;

   int checks = 0;
   int errors = 0;

   serial_word_rx #(
      .WORD_W(W), .LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .com_en(com_en), .data_in(data_in), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .frame_err(frame_err),
      .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: expected FIFO contents plus the frame in progress.
   logic [W-1:0] q[$];
   logic [W-1:0] last_head, acc;
   bit           m_sync, e_ferr, e_ovf, e_busy;
   int           run;
   bit           pc[$], pd[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      pc.delete();
      pd.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
         pc.push_back(1'b0);
         pd.push_back(1'b0);
      end
      last_head = '0;
      acc       = '0;
      m_sync    = 1'b1;
      run       = 0;
      e_ferr    = 1'b0;
      e_ovf     = 1'b0;
      e_busy    = 1'b0;
   endtask

   task automatic model_step(input bit c, input bit d, input bit r);
      bit ce, de, pop;
      pc.push_back(c);
      pd.push_back(d);
      ce     = pc.pop_front();
      de     = pd.pop_front();
      pop    = r && (q.size() > 0);
      e_ferr = 1'b0;
      e_ovf  = 1'b0;
      if (pop) void'(q.pop_front());
      if (m_sync) begin
         if (!ce) m_sync = 1'b0;
         e_busy = 1'b0;
      end else if (ce) begin
         if (run >= LEAD && run < LEAD + W) acc = {acc[W-2:0], de};
         run++;
         e_busy = 1'b1;
      end else begin
         if (run > 0) begin
            if (run == FRAME) begin
               if (q.size() < DEPTH) q.push_back(acc);
               else                  e_ovf = 1'b1;
            end else begin
               e_ferr = 1'b1;
            end
         end
         run    = 0;
         e_busy = 1'b0;
      end
      if (q.size() > 0) last_head = q[0];
   endtask

   // Called in the low clock phase; drives one cycle and checks all outputs after the edge.
   task automatic step(input bit c, input bit d, input bit r);
      com_en  = c;
      data_in = d;
      rd_en   = r;
      model_step(c, d, r);
      @(posedge clk);
      #1;
      check("rd_valid", 64'(rd_valid), 64'(q.size() > 0));
      check("rd_data", 64'(rd_data), 64'(last_head));
      check("frame_err", 64'(frame_err), 64'(e_ferr));
      check("overflow", 64'(overflow), 64'(e_ovf));
      check("busy", 64'(busy), 64'(e_busy));
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #2;
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_frame_err", 64'(frame_err), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
   endtask

   function automatic bit rnd_rd(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   function automatic bit frame_bit(input logic [W-1:0] w, input int k);
      if (k >= LEAD && k < LEAD + W) return w[W-1-(k-LEAD)];
      return bit'($urandom_range(1));
   endfunction

   task automatic send_frame(input logic [W-1:0] w, input int len, input int pct, input bit end_rd);
      for (int k = 0; k < len; k++) step(1'b1, frame_bit(w, k), rnd_rd(pct));
      step(1'b0, bit'($urandom_range(1)), end_rd | rnd_rd(pct));
   endtask

   task automatic idle(input int n, input int pct);
      for (int i = 0; i < n; i++) step(1'b0, bit'($urandom_range(1)), rnd_rd(pct));
   endtask

   initial begin
      com_en  = 1'b0;
      data_in = 1'b0;
      rd_en   = 1'b0;
      do_reset();
      idle(2, 0);

      send_frame(32'hDEADBEEF, FRAME, 0, 1'b0);
      idle(3, 0);
      idle(3, 100);

      send_frame(32'h0BAD0BAD, FRAME - 1, 0, 1'b0);
      send_frame(32'h0BAD0BAD, FRAME + 1, 0, 1'b0);
      send_frame(32'h00000001, FRAME, 0, 1'b0);
      idle(3, 0);
      idle(3, 100);

      for (int i = 1; i <= 5; i++) send_frame(W'(i), FRAME, 0, 1'b0);
      idle(3, 0);
      idle(6, 100);

      for (int i = 0; i < 4; i++) send_frame(W'(32'h100 + i), FRAME, 0, 1'b0);
      send_frame(32'hA5A5A5A5, FRAME, 0, 1'b1);
      idle(3, 0);
      idle(6, 100);

      for (int k = 0; k < 10; k++) step(1'b1, frame_bit(32'h13579BDF, k), 1'b0);
      do_reset();
      for (int k = 10; k < FRAME; k++) step(1'b1, frame_bit(32'h13579BDF, k), 1'b0);
      step(1'b0, 1'b0, 1'b0);
      send_frame(32'hCAFEF00D, FRAME, 0, 1'b0);
      idle(3, 0);
      idle(3, 100);

      send_frame(32'h12345678, FRAME, 0, 1'b0);
      idle(3, 0);
      send_frame($urandom, 260, 30, 1'b0);
      idle(3, 100);

      for (int i = 0; i < 40; i++) begin
         int len, sel, pct;
         sel = int'($urandom_range(9));
         pct = int'($urandom_range(60));
         case (sel)
            0:       len = FRAME - 1;
            1:       len = FRAME + 1;
            2:       len = int'($urandom_range(10, 1));
            default: len = FRAME;
         endcase
         send_frame($urandom, len, pct, 1'b0);
         idle(int'($urandom_range(2)), pct);
      end
      idle(4, 0);
      idle(6, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
